piradma_desc_emitter: RTL
=========================

// Module: piradma_desc_emitter
// PURPOSE
//  Descriptor transmitter: the source end of the 4-word descriptor stream consumed by the MM2S gather engine.
//  Accepts whole descriptors (base, len, flags, extra) on a parallel valid/ready port and queues them in an
//  NDESC-entry ring. Serializes each one as four AXI-Stream beats in the order base, len, flags, extra.
//  Sits between the control/descriptor-table logic and the gather engine's descriptor input.
// PARAMETERS
//  DESC_WORD_WIDTH  32  width of each descriptor word and of m_tdata
//  NDESC_BITS       2   log2 of ring depth; NDESC = 1<<NDESC_BITS entries, all usable
// PORTS
//  aclk       in   1                 sole clock, rising edge
//  aresetn    in   1                 asynchronous, active-low reset
//  s_base     in   DESC_WORD_WIDTH   descriptor word 0
//  s_len      in   DESC_WORD_WIDTH   descriptor word 1
//  s_flags    in   DESC_WORD_WIDTH   descriptor word 2
//  s_extra    in   DESC_WORD_WIDTH   descriptor word 3
//  s_valid    in   1                 descriptor present on s_*
//  s_ready    out  1                 ring can accept a descriptor
//  m_tdata    out  DESC_WORD_WIDTH   serialized descriptor word
//  m_tvalid   out  1                 m_tdata valid
//  m_tready   in   1                 downstream accepts beat
//  m_tlast    out  1                 high on the extra (4th) beat only
//  level      out  NDESC_BITS+1      descriptors queued, including the one being emitted
//  sent_count out  32                descriptors fully emitted since reset
// BEHAVIOUR
//  - Reset (aresetn low, async): head=tail=0, FSM=IDLE, m_tvalid=0, m_tlast=0, m_tdata=0, s_ready=0,
//    level=0, sent_count=0. Ring storage is not reset. s_ready may rise on the first edge after release.
//  - Pointers: head/tail are NDESC_BITS+1 bits wide, with the MSB as the wrap bit. empty = (head==tail).
//    full = (MSBs differ and low bits equal). level = head - tail, modulo 2^(NDESC_BITS+1).
//  - Push: s_ready = ~full, derived from registered pointers. On s_valid & s_ready, write all four words
//    to entry head[NDESC_BITS-1:0]; head++.
//  - FSM states: IDLE, BASE, LEN, FLAGS, EXTRA.
//    - IDLE -> BASE when ~empty.
//    - BASE -> LEN -> FLAGS -> EXTRA, each advancing on m_tvalid & m_tready.
//    - On the EXTRA handshake: tail++, sent_count++ (wraps 2^32-1 -> 0). Next state is BASE if
//      level > 1 (registered value, before the pop), else IDLE.
//  - Outputs: m_tvalid = (state != IDLE). m_tdata = the word of entry tail selected by state, 0 in IDLE.
//    m_tlast = (state == EXTRA).
//  - Latency: descriptor accepted at edge k -> m_tvalid=1 with base beat after edge k+1 (from empty).
//    Back-to-back descriptors stream with no bubble when level > 1 at the EXTRA handshake. If level==1
//    and a push coincides with that handshake, exactly one idle cycle is allowed.
//  - AXIS rule: once m_tvalid=1, m_tdata/m_tlast stay stable until the handshake. The tail entry is never
//    overwritten while it is being emitted; full blocks the push that would overwrite it.
//  - Simultaneous push and EXTRA pop: head++ and tail++ in the same cycle; level is unchanged.
//  - Pointer wrap: indices wrap modulo NDESC and the wrap bit toggles. Order is strictly FIFO.
//  - Reset mid-packet: the beat sequence is truncated immediately (m_tvalid drops). No partial descriptor
//    resumes after release; downstream must be reset together with this block.
// TESTING
//  1. Push {0x1000,0x40,0x1,0xA5} with m_tready=1 -> beats 0x1000,0x40,0x1,0xA5 on 4 consecutive cycles
//     starting edge k+1; m_tlast only on 0xA5; sent_count=1; level returns to 0.
//  2. m_tready=0, push 4 descriptors -> level=4, s_ready=0, 5th push stalls. Then m_tready=1 -> 16 beats
//     in push order; s_ready=1 the cycle after the first EXTRA handshake.
//  3. Random 50% m_tready over 8 descriptors -> m_tdata/m_tlast never change while stalled; all 32 words
//     arrive in order; sent_count=8.
//  4. level=2, push coincident with EXTRA handshake -> level stays 2; next BASE beat follows with no bubble.
//  5. Stream 10 descriptors (tdata = index*0x10+word) through a depth-4 ring -> correct order across the
//     pointer wrap; sent_count=10.
//  6. Assert aresetn low after the LEN beat handshake -> m_tvalid=0 immediately; level=0, sent_count=0.
//     After release a new push emits starting with its BASE word.

Source files
------------

// File: rtl/piradma_desc_emitter.sv
// Descriptor transmitter: queues whole descriptors in a small ring and serializes each
// as four AXI-Stream beats (base, len, flags, extra) toward the gather engine.
module piradma_desc_emitter #(
   parameter int DESC_WORD_WIDTH = 32,
   parameter int NDESC_BITS      = 2
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic [DESC_WORD_WIDTH-1:0] s_base,
   input  logic [DESC_WORD_WIDTH-1:0] s_len,
   input  logic [DESC_WORD_WIDTH-1:0] s_flags,
   input  logic [DESC_WORD_WIDTH-1:0] s_extra,
   input  logic                       s_valid,
   output logic                       s_ready,
   output logic [DESC_WORD_WIDTH-1:0] m_tdata,
   output logic                       m_tvalid,
   input  logic                       m_tready,
   output logic                       m_tlast,
   output logic [NDESC_BITS:0]        level,
   output logic [31:0]                sent_count
);

   localparam int NDESC = 1 << NDESC_BITS;
   localparam int PTR_W = NDESC_BITS + 1;

   typedef enum logic [2:0] {
      IDLE,
      BASE,
      LEN,
      FLAGS,
      EXTRA
   } state_t;

   state_t                           state_q, state_d;
   logic [PTR_W-1:0]                 head_q, head_d;
   logic [PTR_W-1:0]                 tail_q, tail_d;
   logic [31:0]                      sent_count_q, sent_count_d;
   logic                             ready_en_q;
   logic [3:0][DESC_WORD_WIDTH-1:0]  ring_q [NDESC];

   logic                  empty;
   logic                  full;
   logic                  push;
   logic [NDESC_BITS-1:0] head_idx;
   logic [NDESC_BITS-1:0] tail_idx;

   assign head_idx = head_q[NDESC_BITS-1:0];
   assign tail_idx = tail_q[NDESC_BITS-1:0];
   assign empty    = (head_q == tail_q);
   assign full     = (head_q[PTR_W-1] != tail_q[PTR_W-1]) && (head_idx == tail_idx);

   // ready_en_q keeps s_ready low while in reset even though the empty ring is not full
   assign s_ready    = ready_en_q & ~full;
   assign push       = s_valid & s_ready;
   assign level      = head_q - tail_q;
   assign sent_count = sent_count_q;
   assign m_tvalid   = (state_q != IDLE);
   assign m_tlast    = (state_q == EXTRA);

   always_comb begin
      m_tdata = '0;
      case (state_q)
         BASE:    m_tdata = ring_q[tail_idx][0];
         LEN:     m_tdata = ring_q[tail_idx][1];
         FLAGS:   m_tdata = ring_q[tail_idx][2];
         EXTRA:   m_tdata = ring_q[tail_idx][3];
         default: m_tdata = '0;
      endcase
   end

   // m_tvalid is high in every non-IDLE state, so m_tready alone marks a beat handshake
   always_comb begin
      state_d      = state_q;
      head_d       = head_q;
      tail_d       = tail_q;
      sent_count_d = sent_count_q;
      if (push) begin
         head_d = head_q + PTR_W'(1);
      end
      case (state_q)
         IDLE:  if (!empty)  state_d = BASE;
         BASE:  if (m_tready) state_d = LEN;
         LEN:   if (m_tready) state_d = FLAGS;
         FLAGS: if (m_tready) state_d = EXTRA;
         EXTRA: begin
            if (m_tready) begin
               tail_d       = tail_q + PTR_W'(1);
               sent_count_d = sent_count_q + 32'd1;
               state_d      = (level > PTR_W'(1)) ? BASE : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q      <= IDLE;
         head_q       <= '0;
         tail_q       <= '0;
         sent_count_q <= '0;
         ready_en_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         sent_count_q <= sent_count_d;
         ready_en_q   <= 1'b1;
      end
   end

   // Storage is deliberately unreset; full prevents overwriting the entry being emitted
   always_ff @(posedge aclk) begin
      if (push) begin
         ring_q[head_idx] <= {s_extra, s_flags, s_len, s_base};
      end
   end

endmodule
